irq_source_ctrl: RTL and testbench
==================================

# irq_source_ctrl

External interrupt controller that drives the core's single `interrupter` input and consumes the core's CP0 status outputs (`ir`, `ir_en`, `ir_valid`, `ir_wait`, `jump_en`) as its acknowledge and return handshake. It collects up to `NUM_SRC` edge-triggered device requests into a pending register and applies a mask and fixed priority. It raises one request at a time to the core and holds the winning source ID stable until the core takes the interrupt and returns with ERET. It sits at the SoC top level between peripherals and `mips_core`.

## Interface
- `NUM_SRC`, 4, number of request sources (1..16)
- `ID_W`, 2, width of source ID; must satisfy 2^ID_W >= NUM_SRC
- `clk` input 1 main clock, all state on rising edge
- `rst_n` input 1 reset, asynchronous, active-low
- `irq_src` input NUM_SRC device request lines, rising edge = request
- `mask_wen` input 1 write strobe for mask register
- `mask_din` input NUM_SRC mask value, 1 = source enabled
- `ir_en` input 1 core interrupt enable (CP0 status)
- `ir_valid` input 1 core pulse: interrupt taken this cycle (acknowledge)
- `ir` input 1 core: interrupt in service
- `ir_wait` input 1 core: request seen, pipeline draining
- `jump_en` input 1 core forced jump (entry or ERET)
- `interrupter` output 1 request to core
- `irq_id` output ID_W ID of the request currently offered or in service
- `in_service` output 1 high from acknowledge to ERET
- `pending` output NUM_SRC pending register
- `dropped` output 1 sticky: an edge arrived on an already-pending source
- `serv_cnt` output 8 count of acknowledged interrupts, wraps 255→0

## Operation
- Edge detect: `src_prev <= irq_src_s`. `pending[i]` sets when `irq_src_s[i] & ~src_prev[i]`. `irq_src_s` is `irq_src` itself, or its synchronised copy (see Configuration).
- Edge detect on a set `pending[i]`: the bit stays 1 and `dropped` is set. `dropped` clears only on `mask_wen`.
- `mask_wen`: the mask loads at the edge. Selection in that same cycle uses the old mask.
- Eligible: `pending & mask`. Winner = lowest index eligible; index 0 has highest priority.
- FSM states: IDLE, REQ, SERV, DONE.
  - IDLE: if `ir_en` and any eligible bit, latch winner into `irq_id` → REQ. Otherwise stay.
  - REQ: `interrupter`=1. `irq_id` is frozen; later higher-priority arrivals or mask changes do not alter it. On `ir_valid`: clear `pending[irq_id]`, increment `serv_cnt` → SERV. `ir_wait` only holds REQ.
  - SERV: `in_service`=1, `interrupter`=0. On `jump_en & ~ir_valid` (ERET) → DONE.
  - DONE: one cooldown cycle so the core's `ir` can fall → IDLE.
- `ir_valid` in IDLE, SERV or DONE: ignored. `jump_en` outside SERV: ignored.
- Ack-cycle clear and a new edge on the same source in the same cycle: set wins, so `pending` stays 1.
- No nesting. Arrivals during SERV/DONE only pend.

## Timing
- Reset (async, `rst_n`=0): FSM=IDLE; `interrupter`=0, `irq_id`=0, `in_service`=0, `pending`=0, `dropped`=0, `serv_cnt`=0, mask=all ones, `src_prev`=0, sync flops=0. Reset mid-REQ or mid-SERV drops all state immediately, with no handshake.
- All outputs are registered.
- Request latency without sync: `irq_src` rises before edge k → `pending` high after k → `interrupter` high after k+1.
- `interrupter` falls at the edge that samples `ir_valid`=1. `in_service` rises at that same edge.
- ERET sampled at edge m → `in_service` low after m. The earliest next `interrupter` is after m+2.

## Configuration
- `IRQ_SYNC_EN` defined: each `irq_src` bit passes through a 2-flop synchroniser before edge detect. Request latency becomes 4 cycles, and asynchronous device lines are allowed.
- `IRQ_SYNC_EN` undefined: `irq_src` is used directly and must be synchronous to `clk`. Request latency is 2 cycles.

## Test plan
- Single request (no sync): pulse `irq_src[2]` before edge 5 → `pending`=4'b0100 after 5, `interrupter`=1 and `irq_id`=2 after 6. `ir_valid` at edge 9 → `interrupter`=0, `in_service`=1, `pending`=0, `serv_cnt`=1.
- Priority and freeze: sources 3 and 1 rise together → `irq_id`=1. Source 0 rises during REQ → `irq_id` stays 1. After ERET plus DONE, the next offer has `irq_id`=0, then `irq_id`=3.
- Mask and enable: mask=4'b1110, source 0 rises → no `interrupter`. `ir_en`=0 with source 1 pending → no `interrupter`. Raising `ir_en` → `interrupter` after 1 cycle with `irq_id`=1.
- Overflow and same-cycle set: second edge on pending source 2 → `dropped`=1. New edge on the source at its ack edge → `pending[irq_id]` remains 1. `mask_wen` → `dropped`=0.
- Reset mid-service: in SERV, drop `rst_n` between edges → all outputs 0 and mask all ones immediately, before the next clock.
- `serv_cnt` wrap: 256 full request/ack/ERET cycles → `serv_cnt` returns to 0. With `IRQ_SYNC_EN` defined, request latency measures 4 cycles.

Source files
------------

// File: rtl/irq_source_ctrl.sv
// irq_source_ctrl: collects device edges, applies mask and fixed priority, offers one request to mips_core.
// Latency: irq_src edge to interrupter = 2 cycles (4 with IRQ_SYNC_EN, which adds a 2-flop input synchroniser).
// Backpressure: one request in flight; edges arriving before ERET plus one cooldown cycle only pend.
module irq_source_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mask_wen,
  input  logic [NUM_SRC-1:0] mask_din,
  input  logic               ir_en,
  input  logic               ir_valid,
  input  logic               ir,
  input  logic               ir_wait,
  input  logic               jump_en,
  output logic               interrupter,
  output logic [ID_W-1:0]    irq_id,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending,
  output logic               dropped,
  output logic [7:0]         serv_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, SERV, DONE} state_t;

  state_t             state, state_nxt;
  logic [NUM_SRC-1:0] irq_src_s, src_prev, mask, eligible, edge_det, ack_clr;
  logic [ID_W-1:0]    winner;
  logic               any_elig, ack, latch_id;

  // ir and ir_wait are status only: REQ already holds until ir_valid, and the
  // DONE cooldown cycle covers the fall of ir, so neither steers the FSM.
  logic unused_core_status;
  assign unused_core_status = ir | ir_wait;

`ifdef IRQ_SYNC_EN
  logic [NUM_SRC-1:0] sync_q1, sync_q2;

  // two-flop synchroniser so device lines may be asynchronous to clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_src;
      sync_q2 <= sync_q1;
    end
  end

  assign irq_src_s = sync_q2;
`else
  assign irq_src_s = irq_src;
`endif

  assign edge_det = irq_src_s & ~src_prev;
  assign eligible = pending & mask;
  assign any_elig = |eligible;
  assign ack      = (state == REQ) && ir_valid;

  // lowest-index eligible source wins; scanning downward leaves the lowest hit
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  // one-hot clear of the source being acknowledged
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ack_clr[i] = ack && (irq_id == ID_W'(i));
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic; ERET is a forced jump that is not an interrupt entry
  always_comb begin
    state_nxt = state;
    latch_id  = 1'b0;
    case (state)
      IDLE: begin
        if (ir_en && any_elig) begin
          state_nxt = REQ;
          latch_id  = 1'b1;
        end
      end
      REQ:     if (ir_valid) state_nxt = SERV;
      SERV:    if (jump_en && !ir_valid) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // registered outputs derived from the next state, ID frozen once latched
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      interrupter <= 1'b0;
      in_service  <= 1'b0;
      irq_id      <= '0;
      serv_cnt    <= '0;
    end else begin
      interrupter <= (state_nxt == REQ);
      in_service  <= (state_nxt == SERV);
      if (latch_id) irq_id   <= winner;
      if (ack)      serv_cnt <= serv_cnt + 8'd1;
    end
  end

  // pending/mask/overflow bookkeeping; a new edge beats the ack clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_prev <= '0;
      pending  <= '0;
      mask     <= '1;
      dropped  <= 1'b0;
    end else begin
      src_prev <= irq_src_s;
      pending  <= (pending & ~ack_clr) | edge_det;
      if (mask_wen) begin
        mask    <= mask_din;
        dropped <= 1'b0;
      end else if (|(edge_det & pending)) begin
        dropped <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_irq_source_ctrl.sv
// tb_irq_source_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Latency: expectations sampled 1ns after each rising edge.
// Backpressure: n/a (bench drives the core handshake directly).
`timescale 1ns/1ps
module tb_irq_source_ctrl;
  localparam int N  = 4;
  localparam int IW = 2;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0]  irq_src = '0, mask_din = '0;
  logic          mask_wen = 0, ir_en = 0, ir_valid = 0, ir = 0, ir_wait = 0, jump_en = 0;
  logic          interrupter, in_service, dropped;
  logic [IW-1:0] irq_id;
  logic [N-1:0]  pending;
  logic [7:0]    serv_cnt;

  int checks = 0, passes = 0;

  irq_source_ctrl #(.NUM_SRC(N), .ID_W(IW)) dut (
    .clk(clk), .rst_n(rst_n), .irq_src(irq_src), .mask_wen(mask_wen), .mask_din(mask_din),
    .ir_en(ir_en), .ir_valid(ir_valid), .ir(ir), .ir_wait(ir_wait), .jump_en(jump_en),
    .interrupter(interrupter), .irq_id(irq_id), .in_service(in_service),
    .pending(pending), .dropped(dropped), .serv_cnt(serv_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference model ----------------
  // phase: 0 waiting, 1 offering, 2 in service, 3 cooldown
  int           m_phase, m_id, m_cnt, t_found;
  logic [N-1:0] m_pend, m_mask, m_prev, ms1, ms2, t_s, t_rise, t_nxt;
  logic         m_drop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0; m_id = 0; m_cnt = 0; m_pend = '0; m_mask = '1;
      m_prev = '0; ms1 = '0; ms2 = '0; m_drop = 1'b0;
    end else begin
`ifdef IRQ_SYNC_EN
      t_s = ms2; ms2 = ms1; ms1 = irq_src;
`else
      t_s = irq_src;
`endif
      t_rise = t_s & ~m_prev;
      t_nxt  = m_pend;
      case (m_phase)
        0: begin
          t_found = -1;
          for (int i = 0; i < N; i++)
            if (t_found < 0 && m_pend[i] && m_mask[i]) t_found = i;
          if (ir_en && t_found >= 0) begin m_id = t_found; m_phase = 1; end
        end
        1: if (ir_valid) begin t_nxt[m_id] = 1'b0; m_cnt = (m_cnt + 1) % 256; m_phase = 2; end
        2: if (jump_en && !ir_valid) m_phase = 3;
        default: m_phase = 0;
      endcase
      if (mask_wen) begin m_drop = 1'b0; m_mask = mask_din; end
      else if ((t_rise & m_pend) != 0) m_drop = 1'b1;
      m_pend = t_nxt | t_rise;
      m_prev = t_s;
    end
  end

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_irq(output int n);
    n = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (interrupter) begin n = c; break; end
    end
  endtask

  task automatic serve();
    ir_valid = 1; tick(); ir_valid = 0;
    jump_en  = 1; tick(); jump_en  = 0;
    tick();
  endtask

  task automatic clean_reset();
    rst_n = 0; #2; rst_n = 1;
    irq_src = '0; mask_wen = 0; ir_valid = 0; jump_en = 0; ir_en = 1;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 0; #12;
    checks++;
    if ({interrupter, irq_id, in_service, pending, dropped, serv_cnt} !== '0)
      $display("FAIL reset_async: got %b want all zero", {interrupter, irq_id, in_service, pending, dropped, serv_cnt});
    else passes++;
    rst_n = 1; ir_en = 1; tick();
    checks++;
    if ({interrupter, in_service, pending, serv_cnt} !== '0)
      $display("FAIL reset_first_clk: got %b want all zero", {interrupter, in_service, pending, serv_cnt});
    else passes++;
  endtask

  task automatic test_single();
    int n;
    irq_src = 4'b0100; wait_irq(n);
    checks++; if (n !== LAT) $display("FAIL single_latency: got %0d want %0d", n, LAT); else passes++;
    checks++; if ({irq_id, pending} !== {2'd2, 4'b0100})
      $display("FAIL single_id_pend: got %0d/%b want 2/0100", irq_id, pending); else passes++;
    ir_wait = 1; tick(); tick(); ir_wait = 0;
    checks++; if (interrupter !== 1'b1) $display("FAIL single_hold: got %b want 1", interrupter); else passes++;
    ir_valid = 1; tick(); ir_valid = 0; irq_src = '0;
    checks++;
    if ({interrupter, in_service, pending, serv_cnt} !== {1'b0, 1'b1, 4'b0000, 8'd1})
      $display("FAIL single_ack: got %b/%b/%b/%0d want 0/1/0000/1", interrupter, in_service, pending, serv_cnt);
    else passes++;
    ir = 1; tick(); jump_en = 1; tick(); jump_en = 0; ir = 0;
    checks++; if ({interrupter, in_service} !== 2'b00)
      $display("FAIL single_eret: got %b want 00", {interrupter, in_service}); else passes++;
    tick();
  endtask

  task automatic test_priority();
    int n;
    irq_src = 4'b1010; wait_irq(n);
    checks++; if (irq_id !== 2'd1 || n !== LAT) $display("FAIL prio_first: got id %0d lat %0d want 1 %0d", irq_id, n, LAT); else passes++;
    irq_src = 4'b1011; tick(); tick();
    checks++; if ({interrupter, irq_id} !== {1'b1, 2'd1})
      $display("FAIL prio_freeze: got %b/%0d want 1/1", interrupter, irq_id); else passes++;
    ir_valid = 1; tick(); ir_valid = 0; irq_src = '0;
    checks++; if (pending !== 4'b1001) $display("FAIL prio_pend: got %b want 1001", pending); else passes++;
    tick(); jump_en = 1; tick(); jump_en = 0;
    checks++; if (in_service !== 1'b0) $display("FAIL prio_eret: got %b want 0", in_service); else passes++;
    tick();
    checks++; if (interrupter !== 1'b0) $display("FAIL prio_cooldown: got %b want 0", interrupter); else passes++;
    tick();
    checks++; if ({interrupter, irq_id} !== {1'b1, 2'd0})
      $display("FAIL prio_next0: got %b/%0d want 1/0", interrupter, irq_id); else passes++;
    serve(); wait_irq(n);
    checks++; if (irq_id !== 2'd3 || n < 0) $display("FAIL prio_next3: got %0d (n=%0d) want 3", irq_id, n); else passes++;
    serve();
  endtask

  task automatic test_mask_enable();
    int n;
    mask_wen = 1; mask_din = 4'b1110; irq_src = 4'b0001; tick(); mask_wen = 0;
    repeat (5) tick();
    checks++; if ({interrupter, pending} !== {1'b0, 4'b0001})
      $display("FAIL mask_block: got %b/%b want 0/0001", interrupter, pending); else passes++;
    ir_en = 0; irq_src = 4'b0011; repeat (5) tick();
    checks++; if ({interrupter, pending} !== {1'b0, 4'b0011})
      $display("FAIL enable_block: got %b/%b want 0/0011", interrupter, pending); else passes++;
    ir_en = 1; tick();
    checks++; if ({interrupter, irq_id} !== {1'b1, 2'd1})
      $display("FAIL enable_raise: got %b/%0d want 1/1", interrupter, irq_id); else passes++;
    serve(); irq_src = '0;
    mask_wen = 1; mask_din = 4'b1111; tick(); mask_wen = 0;
    checks++; if (interrupter !== 1'b0) $display("FAIL mask_old_used: got %b want 0", interrupter); else passes++;
    wait_irq(n);
    checks++; if (irq_id !== 2'd0 || n !== 1) $display("FAIL mask_new: got %0d (n=%0d) want 0 (1)", irq_id, n); else passes++;
    serve();
  endtask

  task automatic test_overflow();
    int n;
    irq_src = 4'b0100; wait_irq(n);
    irq_src = '0; tick(); irq_src = 4'b0100; repeat (LAT) tick();
    checks++; if ({dropped, pending[2]} !== 2'b11)
      $display("FAIL ovf_dropped: got %b want 11", {dropped, pending[2]}); else passes++;
    irq_src = '0; tick(); irq_src = 4'b0100; repeat (LAT - 2) tick();
    ir_valid = 1; tick(); ir_valid = 0;
    checks++;
    if ({in_service, pending, serv_cnt} !== {1'b1, 4'b0100, 8'(m_cnt)})
      $display("FAIL ovf_setwins: got %b/%b/%0d want 1/0100/%0d", in_service, pending, serv_cnt, m_cnt);
    else passes++;
    mask_wen = 1; mask_din = 4'b1111; tick(); mask_wen = 0;
    checks++; if (dropped !== 1'b0) $display("FAIL ovf_clear: got %b want 0", dropped); else passes++;
    jump_en = 1; tick(); jump_en = 0; tick(); irq_src = '0;
    wait_irq(n);
    checks++; if (irq_id !== 2'd2 || n < 0) $display("FAIL ovf_reoffer: got %0d (n=%0d) want 2", irq_id, n); else passes++;
    serve();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) irq_src = irq_src ^ N'($urandom_range(0, 15));
      ir_en    = ($urandom_range(0, 7) != 0);
      ir_valid = ($urandom_range(0, 3) == 0);
      jump_en  = ($urandom_range(0, 3) == 0);
      ir       = $urandom_range(0, 1);
      ir_wait  = $urandom_range(0, 1);
      mask_wen = ($urandom_range(0, 15) == 0);
      mask_din = N'($urandom_range(0, 15));
      tick();
      checks++;
      if ({interrupter, in_service, irq_id, pending, dropped, serv_cnt} !==
          {m_phase == 1, m_phase == 2, IW'(m_id), m_pend, m_drop, 8'(m_cnt)}) begin
        if (bad < 5)
          $display("FAIL random_cyc%0d: got irq=%b srv=%b id=%0d pend=%b drop=%b cnt=%0d want %b %b %0d %b %b %0d",
                   c, interrupter, in_service, irq_id, pending, dropped, serv_cnt,
                   m_phase == 1, m_phase == 2, m_id, m_pend, m_drop, m_cnt);
        bad++;
      end else passes++;
    end
    ir_valid = 0; jump_en = 0; mask_wen = 0; ir = 0; ir_wait = 0;
  endtask

  task automatic test_reset_mid();
    int n;
    clean_reset();
    irq_src = 4'b1000; wait_irq(n);
    ir_valid = 1; tick(); ir_valid = 0; irq_src = '0;
    checks++; if (in_service !== 1'b1) $display("FAIL midrst_serv: got %b want 1", in_service); else passes++;
    #3; rst_n = 0; #1;
    checks++;
    if ({interrupter, irq_id, in_service, pending, dropped, serv_cnt} !== '0)
      $display("FAIL midrst_clear: got %b want all zero", {interrupter, irq_id, in_service, pending, dropped, serv_cnt});
    else passes++;
    #2; rst_n = 1; tick();
    irq_src = 4'b1000; wait_irq(n);
    checks++; if (irq_id !== 2'd3 || n !== LAT) $display("FAIL midrst_mask: got %0d (n=%0d) want 3 (%0d)", irq_id, n, LAT); else passes++;
    serve(); irq_src = '0;
  endtask

  task automatic test_wrap();
    int n;
    clean_reset();
    for (int i = 0; i < 256; i++) begin
      irq_src = 4'b0001; wait_irq(n);
      checks++;
      if (n !== LAT) begin
        $display("FAIL wrap_lat%0d: got %0d want %0d", i, n, LAT);
        break;
      end else passes++;
      ir_valid = 1; tick(); ir_valid = 0; irq_src = '0;
      if (i == 254) begin
        checks++; if (serv_cnt !== 8'd255) $display("FAIL wrap_255: got %0d want 255", serv_cnt); else passes++;
      end
      jump_en = 1; tick(); jump_en = 0; tick();
    end
    checks++; if (serv_cnt !== 8'd0) $display("FAIL wrap_zero: got %0d want 0", serv_cnt); else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask_enable();
    test_overflow();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
